led_pattern_ctrl: RTL and testbench

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

---
 rtl/led_pattern_ctrl.sv | 167 ++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: three debounced push buttons select pattern mode,
// step speed and pause; a base timer plus step divider advance a 4-bit LED
// pattern (rotate left, rotate right, ping-pong, blink).
module led_pattern_ctrl #(
  parameter int unsigned TICK_BASE       = 6_249_999,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_speed,
  input  logic       key_pause,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       paused
);

  localparam int unsigned BASE_W = (TICK_BASE > 0) ? $clog2(TICK_BASE + 1) : 1;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned NKEY   = 3;

  typedef enum logic [1:0] {
    MODE_LEFT     = 2'd0,
    MODE_RIGHT    = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_BLINK    = 2'd3
  } mode_e;

  // Key index order: 0 mode, 1 speed, 2 pause
  logic [NKEY-1:0] key_raw;
  logic [NKEY-1:0] press;

  assign key_raw = {key_pause, key_speed, key_mode};

  for (genvar g = 0; g < NKEY; g++) begin : g_key
    logic            s1;
    logic            s2;
    logic            lvl;
    logic            pulse;
    logic [DB_W-1:0] cnt;

    // Synchronize, debounce, and emit a one-cycle pulse on accepted 1->0
    always_ff @(posedge clk) begin
      if (rst) begin
        s1    <= 1'b1;
        s2    <= 1'b1;
        lvl   <= 1'b1;
        pulse <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= key_raw[g];
        s2    <= s1;
        pulse <= 1'b0;
        if (s2 != lvl) begin
          if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            lvl   <= s2;
            cnt   <= '0;
            pulse <= lvl;  // old level 1 means this is a press
          end else begin
            cnt <= cnt + DB_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign press[g] = pulse;
  end

  mode_e             mode_q;
  logic              dir_up;
  logic [BASE_W-1:0] base_cnt;
  logic [2:0]        step_cnt;
  logic [2:0]        step_max;
  logic              base_tick;
  logic [3:0]        next_led;
  logic              next_dir;
  mode_e             next_mode;
  logic [3:0]        start_led;

  assign mode      = mode_q;
  assign base_tick = (base_cnt == BASE_W'(TICK_BASE));
  assign next_mode = mode_e'(2'(mode_q) + 2'd1);

  // Last step-counter value before a step, (8 >> speed) - 1
  always_comb begin
    step_max = 3'd7;
    case (speed)
      2'd0:    step_max = 3'd7;
      2'd1:    step_max = 3'd3;
      2'd2:    step_max = 3'd1;
      default: step_max = 3'd0;
    endcase
  end

  // Start pattern of the mode being entered
  always_comb begin
    start_led = 4'b0001;
    case (next_mode)
      MODE_LEFT:     start_led = 4'b0001;
      MODE_RIGHT:    start_led = 4'b1000;
      MODE_PINGPONG: start_led = 4'b0001;
      MODE_BLINK:    start_led = 4'b1111;
      default:       start_led = 4'b0001;
    endcase
  end

  // One pattern step in the current mode
  always_comb begin
    next_led = led;
    next_dir = dir_up;
    case (mode_q)
      MODE_LEFT:  next_led = {led[2:0], led[3]};
      MODE_RIGHT: next_led = {led[0], led[3:1]};
      MODE_PINGPONG: begin
        if (dir_up) begin
          next_led = {led[2:0], 1'b0};
          if (led[2]) next_dir = 1'b0;  // arriving at 1000
        end else begin
          next_led = {1'b0, led[3:1]};
          if (led[1]) next_dir = 1'b1;  // arriving at 0001
        end
      end
      MODE_BLINK: next_led = ~led;
      default:    next_led = led;
    endcase
  end

  // Control registers, timers and LED pattern; any press restarts the timers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_LEFT;
      speed    <= 2'd1;
      paused   <= 1'b0;
      led      <= 4'b0001;
      dir_up   <= 1'b1;
      base_cnt <= '0;
      step_cnt <= '0;
    end else if (|press) begin
      base_cnt <= '0;
      step_cnt <= '0;
      if (press[0]) begin
        mode_q <= next_mode;
        led    <= start_led;
        dir_up <= 1'b1;
      end
      if (press[1]) speed  <= speed + 2'd1;
      if (press[2]) paused <= ~paused;
    end else if (!paused) begin
      if (base_tick) begin
        base_cnt <= '0;
        if (step_cnt == step_max) begin
          step_cnt <= '0;
          led      <= next_led;
          dir_up   <= next_dir;
        end else begin
          step_cnt <= step_cnt + 3'd1;
        end
      end else begin
        base_cnt <= base_cnt + BASE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a short base tick and debounce.
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_mode;
  logic       key_speed;
  logic       key_pause;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       paused;

  int n_checks = 0;
  int n_fail   = 0;

  led_pattern_ctrl #(
    .TICK_BASE      (9),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_mode (key_mode),
    .key_speed(key_speed),
    .key_pause(key_pause),
    .led      (led),
    .mode     (mode),
    .speed    (speed),
    .paused   (paused)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges and land on the following falling edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Mask bits {pause, speed, mode}; hold low until the control update edge
  task automatic press_hold(input logic [2:0] m);
    if (m[0]) key_mode  = 1'b0;
    if (m[1]) key_speed = 1'b0;
    if (m[2]) key_pause = 1'b0;
    tick(7);
  endtask

  task automatic release_all();
    key_mode  = 1'b1;
    key_speed = 1'b1;
    key_pause = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_led"},    32'(led),    32'h1);
    chk({tag, "_mode"},   32'(mode),   32'h0);
    chk({tag, "_speed"},  32'(speed),  32'h1);
    chk({tag, "_paused"}, 32'(paused), 32'h0);
  endtask

  logic [3:0] pp_exp [7];

  initial begin
    pp_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    rst = 1'b1;
    release_all();
    tick(3);
    chk_reset_state("reset");
    rst = 1'b0;

    // Free-running LEFT at speed 1: 40 clocks per step
    tick(39);
    chk("left_hold39", 32'(led), 32'h1);
    tick(1);
    chk("left_step40", 32'(led), 32'h2);
    tick(39);
    chk("left_hold79", 32'(led), 32'h2);
    tick(1);
    chk("left_step80", 32'(led), 32'h4);

    // Mode press -> RIGHT, release generates nothing
    key_mode = 1'b0;
    tick(6);
    chk("mode_before", 32'(mode), 32'h0);
    tick(1);
    chk("mode_right", 32'(mode), 32'h1);
    chk("right_start", 32'(led), 32'h8);
    release_all();
    tick(10);
    chk("mode_release", 32'(mode), 32'h1);

    // Second press -> PINGPONG and its sequence
    press_hold(3'b001);
    chk("mode_pp", 32'(mode), 32'h2);
    chk("pp_start", 32'(led), 32'h1);
    release_all();
    tick(39);
    chk("pp_hold", 32'(led), 32'h1);
    tick(1);
    chk("pp_step0", 32'(led), 32'(pp_exp[0]));
    for (int i = 1; i < 7; i++) begin
      tick(40);
      chk($sformatf("pp_step%0d", i), 32'(led), 32'(pp_exp[i]));
    end

    // Reset, then speed 1->2->3->0 with period checks
    rst = 1'b1;
    tick(1);
    chk_reset_state("reset2");
    rst = 1'b0;
    press_hold(3'b010);
    chk("speed2", 32'(speed), 32'h2);
    release_all();
    tick(6);
    press_hold(3'b010);
    chk("speed3", 32'(speed), 32'h3);
    release_all();
    tick(9);
    chk("s3_hold9", 32'(led), 32'h1);
    tick(1);
    chk("s3_step10", 32'(led), 32'h2);
    press_hold(3'b010);
    chk("speed0", 32'(speed), 32'h0);
    chk("speed_led_kept", 32'(led), 32'h2);
    release_all();
    tick(79);
    chk("s0_hold79", 32'(led), 32'h2);
    tick(1);
    chk("s0_step80", 32'(led), 32'h4);

    // Pause at 0100, hold 200 clocks, resume gives a full period
    press_hold(3'b100);
    chk("paused_on", 32'(paused), 32'h1);
    release_all();
    tick(200);
    chk("pause_hold_led", 32'(led), 32'h4);
    chk("pause_hold_flag", 32'(paused), 32'h1);
    press_hold(3'b100);
    chk("paused_off", 32'(paused), 32'h0);
    release_all();
    tick(79);
    chk("resume_hold79", 32'(led), 32'h4);
    tick(1);
    chk("resume_step80", 32'(led), 32'h8);

    // Debounce: 3-cycle glitch ignored, 4-cycle low accepted
    key_mode = 1'b0;
    tick(3);
    key_mode = 1'b1;
    tick(10);
    chk("glitch3", 32'(mode), 32'h0);
    key_mode = 1'b0;
    tick(4);
    key_mode = 1'b1;
    tick(10);
    chk("low4_mode", 32'(mode), 32'h1);
    chk("low4_led", 32'(led), 32'h8);

    // Bounce on release produces no event
    press_hold(3'b001);
    chk("bounce_press", 32'(mode), 32'h2);
    key_mode = 1'b1; tick(2);
    key_mode = 1'b0; tick(2);
    key_mode = 1'b1; tick(1);
    key_mode = 1'b0; tick(3);
    key_mode = 1'b1; tick(12);
    chk("bounce_release", 32'(mode), 32'h2);
    chk("bounce_led", 32'(led), 32'h1);

    // Simultaneous presses: mode, speed and pause all apply
    press_hold(3'b111);
    chk("simul_mode", 32'(mode), 32'h3);
    chk("simul_led", 32'(led), 32'hf);
    chk("simul_speed", 32'(speed), 32'h1);
    chk("simul_paused", 32'(paused), 32'h1);
    release_all();
    tick(6);
    press_hold(3'b010);
    release_all();
    tick(6);
    press_hold(3'b010);
    chk("blink_speed3", 32'(speed), 32'h3);
    release_all();
    tick(50);
    chk("blink_paused_led", 32'(led), 32'hf);
    chk("blink_paused_flag", 32'(paused), 32'h1);

    // One-cycle reset from BLINK/paused/speed 3
    rst = 1'b1;
    tick(1);
    chk_reset_state("reset3");
    rst = 1'b0;
    tick(39);
    chk("post_rst_hold", 32'(led), 32'h1);
    tick(1);
    chk("post_rst_step", 32'(led), 32'h2);

    // Mode press while paused keeps paused
    press_hold(3'b100);
    chk("pause_again", 32'(paused), 32'h1);
    release_all();
    tick(6);
    press_hold(3'b001);
    chk("paused_mode", 32'(mode), 32'h1);
    chk("paused_mode_led", 32'(led), 32'h8);
    chk("paused_mode_flag", 32'(paused), 32'h1);
    release_all();
    tick(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
